fetch_hazard_ctrl: RTL
======================

// Module: fetch_hazard_ctrl
// PURPOSE
//  Stall/redirect controller that sequences the Fetch stage. Tracks in-flight register writers in
//  a per-register scoreboard, raises dependency stall on RAW hazards at decode, and runs a branch
//  FSM that freezes fetch from branch issue until resolution, then drives a one-cycle redirect.
//  Sits between Decode (issue info), Writeback/Memory (retire, branch resolve) and Fetch.
// PARAMETERS
//  PC_WIDTH   16  width of program counter / branch target
//  NUM_REGS   16  architectural registers tracked
//  REG_IDX_W   4  register index width, = clog2(NUM_REGS)
//  CNT_W       2  per-register in-flight writer counter width (max 2**CNT_W-1 writers)
// PORTS
//  I_CLOCK            in   1         clock; all state updates on negedge, matching pipeline latches
//  I_LOCK             in   1         asynchronous, active-low reset
//  I_DE_Valid         in   1         decode holds a real instruction (not a FetchStall bubble)
//  I_DE_IsBranch      in   1         decode instruction is a branch/jump
//  I_DE_Src1Valid     in   1         src1 is read
//  I_DE_Src1          in   REG_IDX_W src1 index
//  I_DE_Src2Valid     in   1         src2 is read
//  I_DE_Src2          in   REG_IDX_W src2 index
//  I_DE_DestValid     in   1         instruction writes a register
//  I_DE_Dest          in   REG_IDX_W dest index
//  I_WB_Valid         in   1         a register write retires this cycle
//  I_WB_Dest          in   REG_IDX_W retiring dest index
//  I_BR_Resolve       in   1         branch outcome known (memory stage)
//  I_BR_NextPC        in   PC_WIDTH  resolved next PC (target if taken, fall-through otherwise)
//  O_Issue            out  1         decode instruction accepted this cycle (comb.)
//  O_DepStallSignal   out  1         RAW hazard stall to Fetch/Decode (comb.)
//  O_BranchStallSignal out 1         branch pending, Fetch must hold PC (registered state)
//  O_BranchAddrSelect out  1         one-cycle redirect strobe to Fetch
//  O_BranchPC         out  PC_WIDTH  redirect target, valid while O_BranchAddrSelect
//  O_ProtoErr         out  1         sticky protocol error flag
// BEHAVIOUR
//  Reset (I_LOCK=0, async): all counters 0, FSM=IDLE, O_BranchPC=0, O_ProtoErr=0; all outputs 0.
//  Hazard = (Src1Valid & cnt[Src1]!=0) | (Src2Valid & cnt[Src2]!=0); uses current (registered) counts,
//   no same-cycle WB bypass: a WB to a blocking reg releases the stall one cycle later.
//  O_DepStallSignal = I_DE_Valid & Hazard & FSM==IDLE.  O_Issue = I_DE_Valid & !Hazard & FSM==IDLE.
//  Scoreboard: on O_Issue & DestValid, cnt[Dest]+=1; on I_WB_Valid, cnt[WB_Dest]-=1; both on same reg
//   in one cycle -> net unchanged. Increment at max saturates, sets O_ProtoErr; decrement at 0 stays 0,
//   sets O_ProtoErr. A branch with DestValid (link) scores like any writer.
//  Branch FSM (registered, negedge):
//   IDLE     : O_Issue & I_DE_IsBranch -> WAIT. Otherwise stay.
//   WAIT     : O_BranchStallSignal=1, no issue. I_BR_Resolve -> latch I_BR_NextPC into O_BranchPC, -> REDIR.
//   REDIR    : O_BranchAddrSelect=1 exactly one cycle, BranchStall=0, no issue (wrong-path slot) -> IDLE.
//  Redirect latency: resolve sampled at edge N, AddrSelect high for cycle N..N+1, issue allowed from N+1.
//  I_BR_Resolve while not in WAIT: ignored, sets O_ProtoErr. WB retires continue in every state.
//  Dep stall and branch stall never both asserted (DepStall qualified by IDLE).
//  O_ProtoErr clears only on reset. Reset mid-WAIT/REDIR: returns to IDLE, redirect dropped.
// STRUCTURE
//  Shared package lg_pipe_pkg: PC_WIDTH, REG_IDX_W, NUM_REGS, branch FSM state enum {IDLE,WAIT,REDIR}.
//  Sub-module hazard_scoreboard: counter array, inc/dec ports, two combinational lookup ports,
//   err output. Top holds FSM, issue/stall logic, target latch.
// TESTING
//  1 Reset: drive I_LOCK=0 mid-WAIT with cnt[3]=1 -> all outputs 0, FSM IDLE, next src=r3 issues.
//  2 RAW: issue dest r5; next cycle src1=r5 -> DepStall=1, Issue=0; WB r5 -> stall drops one cycle later.
//  3 Same-cycle inc/dec: cnt[2]=1, issue dest r2 and WB r2 together -> cnt[2] stays 1, src r2 still stalls.
//  4 Branch: issue branch; BranchStall=1 for 3 cycles; Resolve NextPC=16'h0040 -> AddrSelect=1 one cycle,
//    O_BranchPC=16'h0040, then IDLE, Issue resumes.
//  5 Saturation/underflow: 4 issues to r7 (CNT_W=2) -> cnt=3, ProtoErr=1; WB r1 at cnt 0 -> ProtoErr stays 1.
//  6 Stray Resolve in IDLE -> no AddrSelect, ProtoErr=1; dep-stalled branch does not enter WAIT until clear.

Source files
------------

// File: rtl/lg_pipe_pkg.sv
// Shared pipeline constants and types for the fetch-stage hazard/redirect controller.
package lg_pipe_pkg;

    localparam int PC_WIDTH  = 16;
    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        REDIR = 2'd2
    } br_state_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] idx;
    } reg_ref_t;

    // A source operand only blocks issue when it is actually read.
    function automatic logic operand_blocked(input reg_ref_t src, input logic busy);
        return src.valid & busy;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight writer counters with two read lookups; flags saturation and underflow.
module hazard_scoreboard
    import lg_pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_valid,
    input  logic [REG_IDX_W-1:0] inc_idx,
    input  logic                 dec_valid,
    input  logic [REG_IDX_W-1:0] dec_idx,
    input  logic [REG_IDX_W-1:0] lookup_a_idx,
    output logic                 lookup_a_busy,
    input  logic [REG_IDX_W-1:0] lookup_b_idx,
    output logic                 lookup_b_busy,
    output logic                 err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt      [NUM_REGS];
    logic [CNT_W-1:0]    cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] inc_hit;
    logic [NUM_REGS-1:0] dec_hit;

    assign inc_hit = inc_valid ? (NUM_REGS'(1) << inc_idx) : '0;
    assign dec_hit = dec_valid ? (NUM_REGS'(1) << dec_idx) : '0;

    // An issue and a retire to the same register cancel out, so neither can raise an error.
    always_comb begin
        err = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_next[i] = cnt[i];
            if (inc_hit[i] && !dec_hit[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    err = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end else if (dec_hit[i] && !inc_hit[i]) begin
                if (cnt[i] == '0) begin
                    err = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign lookup_a_busy = (cnt[lookup_a_idx] != '0);
    assign lookup_b_busy = (cnt[lookup_b_idx] != '0);

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch sequencing: RAW dependency stall from the scoreboard plus a branch freeze/redirect FSM.
module fetch_hazard_ctrl
    import lg_pipe_pkg::*;
(
    input  logic                 I_CLOCK,
    input  logic                 I_LOCK,
    input  logic                 I_DE_Valid,
    input  logic                 I_DE_IsBranch,
    input  logic                 I_DE_Src1Valid,
    input  logic [REG_IDX_W-1:0] I_DE_Src1,
    input  logic                 I_DE_Src2Valid,
    input  logic [REG_IDX_W-1:0] I_DE_Src2,
    input  logic                 I_DE_DestValid,
    input  logic [REG_IDX_W-1:0] I_DE_Dest,
    input  logic                 I_WB_Valid,
    input  logic [REG_IDX_W-1:0] I_WB_Dest,
    input  logic                 I_BR_Resolve,
    input  logic [PC_WIDTH-1:0]  I_BR_NextPC,
    output logic                 O_Issue,
    output logic                 O_DepStallSignal,
    output logic                 O_BranchStallSignal,
    output logic                 O_BranchAddrSelect,
    output logic [PC_WIDTH-1:0]  O_BranchPC,
    output logic                 O_ProtoErr
);

    br_state_e           state;
    br_state_e           state_next;
    reg_ref_t            src1;
    reg_ref_t            src2;
    logic                src1_busy;
    logic                src2_busy;
    logic                hazard;
    logic                in_idle;
    logic                sb_err;
    logic                stray_resolve;
    logic [PC_WIDTH-1:0] target;
    logic                proto_err;

    assign src1 = {I_DE_Src1Valid, I_DE_Src1};
    assign src2 = {I_DE_Src2Valid, I_DE_Src2};

    hazard_scoreboard u_scoreboard (
        .clk           (I_CLOCK),
        .rst_n         (I_LOCK),
        .inc_valid     (O_Issue & I_DE_DestValid),
        .inc_idx       (I_DE_Dest),
        .dec_valid     (I_WB_Valid),
        .dec_idx       (I_WB_Dest),
        .lookup_a_idx  (src1.idx),
        .lookup_a_busy (src1_busy),
        .lookup_b_idx  (src2.idx),
        .lookup_b_busy (src2_busy),
        .err           (sb_err)
    );

    assign hazard  = operand_blocked(src1, src1_busy) | operand_blocked(src2, src2_busy);
    assign in_idle = (state == IDLE);

    // Gated by reset so nothing reaches Fetch or the scoreboard while the pipeline is held.
    assign O_Issue          = I_LOCK & I_DE_Valid & ~hazard & in_idle;
    assign O_DepStallSignal = I_LOCK & I_DE_Valid &  hazard & in_idle;

    assign O_BranchStallSignal = (state == WAIT);
    assign O_BranchAddrSelect  = (state == REDIR);
    assign O_BranchPC          = target;
    assign O_ProtoErr          = proto_err;

    assign stray_resolve = I_BR_Resolve & (state != WAIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (O_Issue && I_DE_IsBranch) state_next = WAIT;
            WAIT:    if (I_BR_Resolve) state_next = REDIR;
            REDIR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            state     <= IDLE;
            target    <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_next;
            proto_err <= proto_err | sb_err | stray_resolve;
            if (state == WAIT && I_BR_Resolve) begin
                target <= I_BR_NextPC;
            end
        end
    end

endmodule
